// File: rtl/pe_traffic_gen.sv
// pe_traffic_gen: HNoC processing element that injects PktLimit addressed packets and sinks delivered ones.
// Latency: first o_data_valid two edges after reset release; back-to-back one packet/cycle; GapCycles idle cycles between packets.
// Backpressure: o_data held stable until i_data_ready; receive ready is always 1, or LFSR-driven when PE_BACKPRESSURE_EN is defined.
module pe_traffic_gen #(
    parameter int unsigned address   = 0,
    parameter int unsigned NumPE     = 16,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = $clog2(NumPE),
    parameter int unsigned PktLimit  = 100,
    parameter int unsigned GapCycles = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DataWidth+AddrWidth-1:0] i_data,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    output logic [DataWidth+AddrWidth-1:0] o_data,
    output logic                           o_data_valid,
    input  logic                           i_data_ready,
    input  logic                           done,
    output logic [31:0]                    o_sent_count,
    output logic [31:0]                    o_recv_count,
    output logic                           o_err
);

    localparam int unsigned PktW    = DataWidth + AddrWidth;
    localparam int unsigned SeqW    = DataWidth - AddrWidth;
    localparam int unsigned GapLast = (GapCycles > 0) ? GapCycles - 1 : 0;
    localparam int unsigned GapW    = (GapCycles > 1) ? $clog2(GapCycles) : 1;

    localparam logic [AddrWidth-1:0] MyAddr  = AddrWidth'(address);
    localparam logic [15:0]          Seed    = 16'hACE1 ^ 16'(address);
    localparam logic [31:0]          PktLast = 32'(PktLimit);
    localparam logic [31:0]          CntMax  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q;
    logic [15:0]         lfsr_q;
    logic [15:0]         lfsr_d;
    logic [15:0]         lfsr_step;
    logic [SeqW-1:0]     seq_q;
    logic [SeqW-1:0]     pkt_seq;
    logic [GapW-1:0]     gap_q;
    logic [PktW-1:0]     data_q;
    logic [PktW-1:0]     pkt_d;
    logic                valid_q;
    logic                ready_q;
    logic                err_q;
    logic [31:0]         sent_q;
    logic [31:0]         recv_q;
    logic                send_hs;
    logic                recv_hs;
    logic                last_pkt;
    logic [AddrWidth-1:0] cand;
    logic [AddrWidth-1:0] dest;

    // valid is only ever high in SEND, so the handshake needs no state qualifier
    assign send_hs = valid_q && i_data_ready;
    assign recv_hs = i_data_valid && ready_q;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB
    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef PE_BACKPRESSURE_EN
    // Free-running so the receive-ready pattern keeps changing
    assign lfsr_d = lfsr_step;
`else
    assign lfsr_d = send_hs ? lfsr_step : lfsr_q;
`endif

    // A packet loaded on this edge uses the LFSR state that becomes current on the same edge,
    // so packet k carries the destination derived after k send handshakes.
    assign pkt_seq  = send_hs ? seq_q + SeqW'(1) : seq_q;
    assign cand     = lfsr_d[AddrWidth-1:0];
    assign dest     = (cand == MyAddr) ? MyAddr + AddrWidth'(1) : cand;
    assign pkt_d    = {dest, MyAddr, pkt_seq};
    assign last_pkt = (32'(seq_q) + 32'd1) == PktLast;

    // Injection FSM, receive sink, counters and error flag, all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= Seed;
            seq_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            sent_q  <= '0;
            recv_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
`ifdef PE_BACKPRESSURE_EN
            ready_q <= lfsr_d[15];
`else
            ready_q <= 1'b1;
`endif
            if (recv_hs) begin
                if (recv_q != CntMax) begin
                    recv_q <= recv_q + 32'd1;
                end
                if (i_data[PktW-1:DataWidth] != MyAddr) begin
                    err_q <= 1'b1;
                end
            end
            if (send_hs) begin
                seq_q <= seq_q + SeqW'(1);
                if (sent_q != CntMax) begin
                    sent_q <= sent_q + 32'd1;
                end
            end
            case (state_q)
                IDLE: begin
                    state_q <= done ? FINISH : SEND;
                end
                SEND: begin
                    if (!valid_q) begin
                        // first packet after reset is loaded one edge after leaving IDLE
                        if (done) begin
                            state_q <= FINISH;
                        end else begin
                            valid_q <= 1'b1;
                            data_q  <= pkt_d;
                        end
                    end else if (send_hs) begin
                        if (last_pkt || done) begin
                            valid_q <= 1'b0;
                            state_q <= FINISH;
                        end else if (GapCycles == 0) begin
                            data_q <= pkt_d;
                        end else begin
                            valid_q <= 1'b0;
                            gap_q   <= '0;
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (done) begin
                        state_q <= FINISH;
                    end else if (gap_q == GapW'(GapLast)) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                        data_q  <= pkt_d;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                FINISH: begin
                    state_q <= FINISH;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_data_ready = ready_q;
    assign o_sent_count = sent_q;
    assign o_recv_count = recv_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// tb_pe_traffic_gen: scoreboard bench for two PE instances (back-to-back and gapped injection).
// Expected packets come from a reference model of the packet/LFSR rules, queued on reset release.
// Monitors compare sends, counters, stalls and gap spacing on the falling edge.
module tb_pe_traffic_gen;

    localparam int AddrA = 3;
    localparam int LimA  = 8;
    localparam int AddrB = 5;
    localparam int LimB  = 5;
    localparam int GapB  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [35:0] rx_dat_a = '0;
    logic        rx_vld_a = 1'b0;
    logic        rx_rdy_a;
    logic [35:0] tx_dat_a;
    logic        tx_vld_a;
    logic        tx_rdy_a = 1'b1;
    logic        done_a   = 1'b0;
    logic [31:0] sent_a;
    logic [31:0] recv_a;
    logic        err_a;

    logic [35:0] rx_dat_b = '0;
    logic        rx_vld_b = 1'b0;
    logic        rx_rdy_b;
    logic [35:0] tx_dat_b;
    logic        tx_vld_b;
    logic        tx_rdy_b = 1'b1;
    logic        done_b   = 1'b0;
    logic [31:0] sent_b;
    logic [31:0] recv_b;
    logic        err_b;

    int n_chk  = 0;
    int n_pass = 0;

    logic [35:0] qa[$];
    logic [35:0] qb[$];

    always #5 clk = ~clk;

    pe_traffic_gen #(.address(AddrA), .NumPE(16), .DataWidth(32), .PktLimit(LimA), .GapCycles(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_data(rx_dat_a), .i_data_valid(rx_vld_a), .o_data_ready(rx_rdy_a),
        .o_data(tx_dat_a), .o_data_valid(tx_vld_a), .i_data_ready(tx_rdy_a),
        .done(done_a), .o_sent_count(sent_a), .o_recv_count(recv_a), .o_err(err_a)
    );

    pe_traffic_gen #(.address(AddrB), .NumPE(16), .DataWidth(32), .PktLimit(LimB), .GapCycles(GapB)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_data(rx_dat_b), .i_data_valid(rx_vld_b), .o_data_ready(rx_rdy_b),
        .o_data(tx_dat_b), .o_data_valid(tx_vld_b), .i_data_ready(tx_rdy_b),
        .done(done_b), .o_sent_count(sent_b), .o_recv_count(recv_b), .o_err(err_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: packet k = {dest, src, k}; dest from the LFSR after k steps, never the sender itself
    function automatic logic [35:0] exp_pkt(input int addr, input int k);
        logic [15:0] l;
        logic [3:0]  a;
        logic [3:0]  d;
        a = addr[3:0];
        l = 16'hACE1 ^ 16'(addr);
        for (int i = 0; i < k; i++) begin
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        d = (l[3:0] == a) ? a + 4'd1 : l[3:0];
        return {d, a, 28'(k)};
    endfunction

    // Monitor A: sends vs scoreboard, stall stability, counters, misroute flag
    int          exp_sent_a = 0;
    int          exp_recv_a = 0;
    logic        exp_err_a  = 1'b0;
    logic        stall_a    = 1'b0;
    logic [35:0] held_a     = '0;
    always @(negedge clk) begin
        if (rst) begin
            exp_sent_a = 0;
            exp_recv_a = 0;
            exp_err_a  = 1'b0;
            stall_a    = 1'b0;
            qa.delete();
        end else begin
            chk("a_sent_count", sent_a, exp_sent_a);
            chk("a_recv_count", recv_a, exp_recv_a);
            chk("a_err", err_a, exp_err_a);
            if (stall_a) begin
                chk("a_stall_valid", tx_vld_a, 1);
                chk("a_stall_data", tx_dat_a, held_a);
            end
            stall_a = tx_vld_a && !tx_rdy_a;
            held_a  = tx_dat_a;
            if (tx_vld_a && tx_rdy_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_send", 1, 0);
                end else begin
                    chk("a_pkt", tx_dat_a, qa.pop_front());
                end
                chk("a_dest_not_self", tx_dat_a[35:32] == 4'(AddrA), 0);
                exp_sent_a++;
            end
            if (rx_vld_a && rx_rdy_a) begin
                exp_recv_a++;
                if (rx_dat_a[35:32] != 4'(AddrA)) exp_err_a = 1'b1;
            end
        end
    end

    // Monitor B: sends vs scoreboard and spacing of GapB+1 cycles between valid packets
    int   exp_sent_b = 0;
    int   dist_b     = 0;
    logic pend_b     = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_sent_b = 0;
            pend_b     = 1'b0;
            dist_b     = 0;
            qb.delete();
        end else begin
            chk("b_sent_count", sent_b, exp_sent_b);
            if (pend_b) dist_b++;
            if (tx_vld_b && pend_b) begin
                chk("b_gap_spacing", dist_b, GapB + 1);
                pend_b = 1'b0;
            end
            if (tx_vld_b && tx_rdy_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_send", 1, 0);
                end else begin
                    chk("b_pkt", tx_dat_b, qb.pop_front());
                end
                exp_sent_b++;
                pend_b = 1'b1;
                dist_b = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_vld_a = 1'b0;
        tx_rdy_a = 1'b1;
        done_a   = 1'b0;
        repeat (3) tick();
        chk("rst_data", tx_dat_a, 0);
        chk("rst_valid", tx_vld_a, 0);
        chk("rst_ready", rx_rdy_a, 0);
        chk("rst_sent", sent_a, 0);
        chk("rst_recv", recv_a, 0);
        chk("rst_err", err_a, 0);
        rst = 1'b0;
        for (int k = 0; k < LimA; k++) qa.push_back(exp_pkt(AddrA, k));
        for (int k = 0; k < LimB; k++) qb.push_back(exp_pkt(AddrB, k));
        tick();
        chk("first_edge_ready", rx_rdy_a, 1);
        chk("first_edge_valid", tx_vld_a, 0);
        tick();
        chk("second_edge_valid", tx_vld_a, 1);
    endtask

    logic [3:0] rx_dst[6];
    int         rx_i;

    initial begin
        rx_dst = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd3, 4'd3};

        // Run 1: random output stalls with a fixed 5-cycle stall, receive 3 good then 1 misrouted
        do_reset();
        rx_i = 0;
        for (int c = 0; c < 60; c++) begin
            if (c >= 2 && c < 7) tx_rdy_a = 1'b0;
            else                 tx_rdy_a = ($urandom_range(0, 3) != 0);
            if (rx_i < 6 && $urandom_range(0, 1) == 1) begin
                rx_vld_a = 1'b1;
                rx_dat_a = {rx_dst[rx_i], 4'($urandom_range(0, 15)), 28'($urandom)};
                if (rx_rdy_a) rx_i++;
            end else begin
                rx_vld_a = 1'b0;
            end
            tick();
        end
        rx_vld_a = 1'b0;
        tx_rdy_a = 1'b1;
        for (int i = 0; i < 200 && tx_vld_a; i++) tick();
        repeat (3) tick();
        chk("a_final_sent", sent_a, LimA);
        chk("a_finish_valid", tx_vld_a, 0);
        chk("a_queue_drained", qa.size(), 0);
        chk("a_final_recv", recv_a, rx_i);
        chk("a_final_err", err_a, 1);
        chk("b_final_sent", sent_b, LimB);
        chk("b_finish_valid", tx_vld_b, 0);
        chk("b_queue_drained", qb.size(), 0);

        // Run 2: reset asserted mid-stream forces outputs low at once
        do_reset();
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_data", tx_dat_a, 0);
        chk("midrst_valid", tx_vld_a, 0);
        chk("midrst_sent", sent_a, 0);
        chk("midrst_ready", rx_rdy_a, 0);
        chk("midrst_b_valid", tx_vld_b, 0);

        // Run 3: repeat of the destination sequence, then done raised while stalled
        do_reset();
        for (int i = 0; i < 50 && sent_a != 3; i++) tick();
        chk("wait_sent3", sent_a, 3);
        tx_rdy_a = 1'b0;
        repeat (2) tick();
        done_a = 1'b1;
        repeat (3) tick();
        chk("done_hold_valid", tx_vld_a, 1);
        chk("done_hold_sent", sent_a, 3);
        tx_rdy_a = 1'b1;
        for (int i = 0; i < 20 && tx_vld_a; i++) tick();
        repeat (4) tick();
        chk("done_final_sent", sent_a, 4);
        chk("done_finish_valid", tx_vld_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
